// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Width of each per-requester accepted-word counter
    localparam int unsigned STAT_W = 16;

    // Width of the burst word counter; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned burst);
        return (burst > 1) ? int'($clog2(burst)) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    int          w_j;
    logic [IW-1:0] w_jj;

    // Scan from the farthest offset down so the nearest request to ptr wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = |i_req;
        w_j      = 0;
        w_jj     = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_j  = (int'(i_ptr) + k) % int'(NREQ);
            w_jj = IW'(w_j);
            if (i_req[w_jj]) begin
                o_onehot       = '0;
                o_onehot[w_jj] = 1'b1;
                o_idx          = w_jj;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the fifo write port among NREQ producers.
// Optional per-requester word counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                   clk_w,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DW-1:0]     req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic                   wre,
    output logic [DW-1:0]          wrd,
    input  logic                   full,
    output logic                   busy,
    output logic [NREQ*STAT_W-1:0] stat_words
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = cnt_width(BURST);

    arb_state_e      r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt,   w_gnt_nxt;
    logic [IW-1:0]   r_gidx,  w_gidx_nxt;
    logic [IW-1:0]   r_ptr,   w_ptr_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic            r_busy,  w_busy_nxt;

    logic [NREQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_wre;
    logic [NREQ-1:0] w_ack;
    logic [DW-1:0]   w_data_arr [NREQ];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Unpack requester data lanes for the write-data mux
    for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_lane
        assign w_data_arr[gi] = req_data[gi*DW +: DW];
    end

    // Write strobe only in XFER with the owner still requesting and fifo not full; held off in reset
    assign w_wre = (r_state == ST_XFER) && req[r_gidx] && !full && reset;
    assign w_ack = r_gnt & {NREQ{w_wre}};

    assign wre  = w_wre;
    assign ack  = w_ack;
    assign wrd  = w_data_arr[r_gidx];
    assign gnt  = r_gnt;
    assign busy = r_busy;

    // State register with synchronous active-low reset
    always_ff @(posedge clk_w) begin
        if (!reset) begin
            r_state <= ST_ARB;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state: grant on any request in ARB, release on last word, burst limit or dropped request
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            ST_ARB: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_XFER;
                    w_gnt_nxt   = w_pick_oh;
                    w_gidx_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_wre) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if ((w_wre && req_last[r_gidx]) ||
                    (w_wre && (r_cnt == CW'(BURST - 1))) ||
                    !req[r_gidx]) begin
                    w_state_nxt = ST_ARB;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + IW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NREQ];

    // Saturating accepted-word counters, one per requester
    always_ff @(posedge clk_w) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (w_ack[i] && (r_stat[i] != '1)) begin
                    r_stat[i] <= r_stat[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar gs = 0; gs < int'(NREQ); gs++) begin : g_stat
        assign stat_words[gs*STAT_W +: STAT_W] = r_stat[gs];
    end
`else
    assign stat_words = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST=4).
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic                 clk_w = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic                 wre;
    logic [DW-1:0]        wrd;
    logic                 full;
    logic                 busy;
    logic [NREQ*16-1:0]   stat_words;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk_w      (clk_w),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .ack        (ack),
        .wre        (wre),
        .wrd        (wrd),
        .full       (full),
        .busy       (busy),
        .stat_words (stat_words)
    );

    always #5 clk_w = ~clk_w;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk_w);
    endtask

    function automatic logic [NREQ-1:0] oh(input int g);
        return NREQ'(1) << g;
    endfunction

    logic [63:0] stat_exp;

    initial begin
`ifdef FIFO_ARB_STATS_EN
        stat_exp = 64'h0000_0000_0005_0000;
`else
        stat_exp = 64'h0;
`endif
        reset = 1'b0; req = '0; req_data = '0; req_last = '0; full = 1'b0;
        cyc(); cyc(); #1;
        chk("rst_gnt",  64'(gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_wre",  64'(wre), 64'h0);
        chk("rst_stat", stat_words, 64'h0);

        // Single-word packet from requester 0
        cyc(); reset = 1'b1; #1;
        cyc(); #1;
        chk("idle_gnt", 64'(gnt), 64'h0);
        req = 4'b0001; req_data = 32'h4030_20A5; req_last = 4'b0001; #1;
        chk("t1_arb_wre", 64'(wre), 64'h0);
        cyc(); #1;
        chk("t1_gnt",  64'(gnt),  64'h1);
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_wre",  64'(wre),  64'h1);
        chk("t1_wrd",  64'(wrd),  64'hA5);
        chk("t1_ack",  64'(ack),  64'h1);
        cyc(); req = 4'b0011; req_last = 4'b0010; req_data = 32'h4030_2010; #1;
        chk("t1_rel_gnt",  64'(gnt),  64'h0);
        chk("t1_rel_busy", 64'(busy), 64'h0);
        cyc(); #1;
        chk("t1_ptr_next", 64'(gnt), 64'h2);
        chk("t1_ptr_wrd",  64'(wrd), 64'h20);
        cyc(); req = '0; req_last = '0; #1;
        chk("t1_end_gnt", 64'(gnt), 64'h0);

        // All four requesting, no last: fair rotation with full bursts
        reset = 1'b0;
        cyc(); cyc(); reset = 1'b1; req = 4'b1111; #1;
        chk("t2_idle0", 64'(gnt), 64'h0);
        for (int gi = 0; gi < 5; gi++) begin
            for (int w = 0; w < BURST; w++) begin
                cyc(); #1;
                chk("t2_gnt", 64'(gnt), 64'(oh(gi % NREQ)));
                chk("t2_ack", 64'(ack), 64'(oh(gi % NREQ)));
                chk("t2_wrd", 64'(wrd), 64'(8'h10 * (gi % NREQ + 1)));
            end
            cyc(); #1;
            chk("t2_gap_gnt", 64'(gnt), 64'h0);
            chk("t2_gap_wre", 64'(wre), 64'h0);
        end
        req = 4'b0100;

        // Requester 2 stalled by full for three cycles
        cyc(); #1;
        chk("t3_gnt", 64'(gnt), 64'h4);
        chk("t3_ack", 64'(ack), 64'h4);
        for (int k = 0; k < 3; k++) begin
            cyc(); full = 1'b1; #1;
            chk("t3_full_wre", 64'(wre), 64'h0);
            chk("t3_full_ack", 64'(ack), 64'h0);
            chk("t3_full_gnt", 64'(gnt), 64'h4);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); full = 1'b0; #1;
            chk("t3_resume_ack", 64'(ack), 64'h4);
        end
        cyc(); req = 4'b1010; #1;
        chk("t3_release", 64'(gnt), 64'h0);

        // Reset mid-burst at cnt=2
        cyc(); #1;
        chk("t4_gnt", 64'(gnt), 64'h8);
        chk("t4_wrd", 64'(wrd), 64'h40);
        cyc(); #1;
        chk("t4_ack2", 64'(ack), 64'h8);
        cyc(); reset = 1'b0; #1;
        chk("t4_wre_in_rst", 64'(wre), 64'h0);
        chk("t4_ack_in_rst", 64'(ack), 64'h0);
        cyc(); #1;
        chk("t4_gnt",  64'(gnt),  64'h0);
        chk("t4_busy", 64'(busy), 64'h0);
        chk("t4_stat", stat_words, 64'h0);
        reset = 1'b1;

        // Granted requester drops its request after one word
        cyc(); #1;
        chk("t5_gnt", 64'(gnt), 64'h2);
        chk("t5_ack", 64'(ack), 64'h2);
        cyc(); req = 4'b1001; #1;
        chk("t5_drop_wre", 64'(wre), 64'h0);
        chk("t5_drop_ack", 64'(ack), 64'h0);
        chk("t5_drop_gnt", 64'(gnt), 64'h2);
        cyc(); #1;
        chk("t5_rel_gnt", 64'(gnt), 64'h0);
        cyc(); #1;
        chk("t5_ptr_adv", 64'(gnt), 64'h8);
        chk("t5_ack3",    64'(ack), 64'h8);
        cyc(); req = '0;

        // Requester 1 writes five words over two grants
        reset = 1'b0;
        cyc(); cyc(); reset = 1'b1; req = 4'b0010; req_last = '0;
        for (int w = 0; w < BURST; w++) begin
            cyc(); #1;
            chk("t6_ack", 64'(ack), 64'h2);
        end
        cyc(); #1;
        chk("t6_gap", 64'(gnt), 64'h0);
        cyc(); req_last = 4'b0010; #1;
        chk("t6_ack5", 64'(ack), 64'h2);
        cyc(); req = '0; req_last = '0; #1;
        chk("t6_stat", stat_words, stat_exp);
        cyc(); #1;
        chk("t6_busy", 64'(busy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
